// File: rtl/ncc_sequencer.sv
// Control FSM for the 16x16 NCC PE grid: loads a 64-word descriptor, streams the window, tags results with their column.
// Latency: load strobes are combinational with the accepting handshake; result_valid/result_col appear 1 cycle after the accepting beat.
// Backpressure: ready is a pure function of state; a low valid freezes all counters and strobes (the grid holds).
// Ports: clk/rst (sync, active-high); start; desc_valid/desc_ready; win_valid/win_ready;
//        load_desc_now/load_row/load_col_group; load_win_reg/load_acc_sum_reg;
//        result_valid/result_col; busy; done.
module ncc_sequencer #(
  parameter int ROWS       = 16,
  parameter int COL_GROUPS = 4,
  parameter int WIN_WIDTH  = 640,
  parameter int PIPE_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         desc_valid,
  output logic                         desc_ready,
  input  logic                         win_valid,
  output logic                         win_ready,
  output logic                         load_desc_now,
  output logic [ROWS-1:0]              load_row,
  output logic [COL_GROUPS-1:0]        load_col_group,
  output logic                         load_win_reg,
  output logic                         load_acc_sum_reg,
  output logic                         result_valid,
  output logic [$clog2(WIN_WIDTH)-1:0] result_col,
  output logic                         busy,
  output logic                         done
);

  localparam int RW = $clog2(ROWS);
  localparam int GW = $clog2(COL_GROUPS);
  localparam int BW = $clog2(WIN_WIDTH + 1);
  localparam int CW = $clog2(WIN_WIDTH);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_DESC_LOAD = 2'd1;
  localparam logic [1:0] S_SCAN      = 2'd2;
  localparam logic [1:0] S_DONE      = 2'd3;

  localparam logic [ROWS-1:0]       ROW_ONE = {{(ROWS-1){1'b0}}, 1'b1};
  localparam logic [COL_GROUPS-1:0] GRP_ONE = {{(COL_GROUPS-1){1'b0}}, 1'b1};

  logic [1:0]    state;
  logic [RW-1:0] row_cnt;
  logic [GW-1:0] grp_cnt;
  logic [BW-1:0] beat_cnt;

  logic desc_acc;
  logic win_acc;
  logic last_grp;
  logic last_word;
  logic last_beat;
  logic beat_has_result;

  assign desc_ready = (state == S_DESC_LOAD);
  assign win_ready  = (state == S_SCAN);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);

  assign desc_acc = desc_valid && desc_ready;
  assign win_acc  = win_valid && win_ready;

  assign last_grp  = (grp_cnt == GW'(COL_GROUPS - 1));
  assign last_word = last_grp && (row_cnt == RW'(ROWS - 1));
  assign last_beat = (beat_cnt == BW'(WIN_WIDTH - 1));

  // The PE chain needs PIPE_DEPTH beats before its first accumulator is
  // meaningful, so beats 0..PIPE_DEPTH-2 only prime the chain.
  assign beat_has_result = (beat_cnt >= BW'(PIPE_DEPTH - 1));

  assign load_desc_now    = desc_acc;
  assign load_row         = desc_acc ? (ROW_ONE << row_cnt) : '0;
  assign load_col_group   = desc_acc ? (GRP_ONE << grp_cnt) : '0;
  assign load_win_reg     = win_acc;
  assign load_acc_sum_reg = win_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      row_cnt      <= '0;
      grp_cnt      <= '0;
      beat_cnt     <= '0;
      result_valid <= 1'b0;
      result_col   <= '0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) state <= S_DESC_LOAD;
        end
        S_DESC_LOAD: begin
          if (desc_acc) begin
            if (last_grp) begin
              grp_cnt <= '0;
              // Explicit wrap keeps the counters at 0 for the next match
              // even if ROWS is not a power of two.
              row_cnt <= last_word ? '0 : row_cnt + RW'(1);
            end else begin
              grp_cnt <= grp_cnt + GW'(1);
            end
            if (last_word) state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (win_acc) begin
            if (beat_has_result) begin
              result_valid <= 1'b1;
              result_col   <= CW'(beat_cnt - BW'(PIPE_DEPTH - 1));
            end
            if (last_beat) begin
              beat_cnt <= '0;
              state    <= S_DONE;
            end else begin
              beat_cnt <= beat_cnt + BW'(1);
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ncc_sequencer.sv
// Bench for ncc_sequencer: directed scenario steps with random valid patterns, checked every cycle
// against a count-based model (words loaded, beats accepted) plus directed end-of-scenario checks.
// Ports: drives every DUT input, observes every DUT output.
module tb_ncc_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       desc_valid;
  logic       desc_ready;
  logic       win_valid;
  logic       win_ready;
  logic       load_desc_now;
  logic [15:0] load_row;
  logic [3:0] load_col_group;
  logic       load_win_reg;
  logic       load_acc_sum_reg;
  logic       result_valid;
  logic [9:0] result_col;
  logic       busy;
  logic       done;

  ncc_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .desc_valid       (desc_valid),
    .desc_ready       (desc_ready),
    .win_valid        (win_valid),
    .win_ready        (win_ready),
    .load_desc_now    (load_desc_now),
    .load_row         (load_row),
    .load_col_group   (load_col_group),
    .load_win_reg     (load_win_reg),
    .load_acc_sum_reg (load_acc_sum_reg),
    .result_valid     (result_valid),
    .result_col       (result_col),
    .busy             (busy),
    .done             (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: which phase of a match we are in and how many
  // descriptor words / window beats have been accepted so far.
  // phase: 0 idle, 1 loading descriptor, 2 scanning window, 3 done cycle.
  int phase = 0;
  int words = 0;
  int beats = 0;
  int m_rv  = 0;
  int m_rc  = 0;

  // Event tallies observed on the DUT, compared to constants after scenarios.
  int cnt_ldn = 0;
  int cnt_lw  = 0;
  int cnt_rv  = 0;
  int last_row = 0;
  int last_grp = 0;
  int last_rc  = 0;
  int done_rc  = -1;
  int done_rv  = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, check all outputs mid-cycle, then advance model.
  task automatic step(input logic r, input logic s, input logic dv, input logic wv);
    int e_ldn;
    int e_lw;
    rst = r; start = s; desc_valid = dv; win_valid = wv;
    @(negedge clk);
    e_ldn = (phase == 1 && dv) ? 1 : 0;
    e_lw  = (phase == 2 && wv) ? 1 : 0;
    chk("busy",             32'(busy),             32'(phase != 0));
    chk("done",             32'(done),             32'(phase == 3));
    chk("desc_ready",       32'(desc_ready),       32'(phase == 1));
    chk("win_ready",        32'(win_ready),        32'(phase == 2));
    chk("load_desc_now",    32'(load_desc_now),    32'(e_ldn));
    chk("load_row",         32'(load_row),         e_ldn ? (32'd1 << (words / 4)) : 32'd0);
    chk("load_col_group",   32'(load_col_group),   e_ldn ? (32'd1 << (words % 4)) : 32'd0);
    chk("load_win_reg",     32'(load_win_reg),     32'(e_lw));
    chk("load_acc_sum_reg", 32'(load_acc_sum_reg), 32'(e_lw));
    chk("result_valid",     32'(result_valid),     32'(m_rv));
    chk("result_col",       32'(result_col),       32'(m_rc));
    if (load_desc_now) begin
      cnt_ldn++;
      last_row = int'(load_row);
      last_grp = int'(load_col_group);
    end
    if (load_win_reg) cnt_lw++;
    if (result_valid) begin
      cnt_rv++;
      last_rc = int'(result_col);
    end
    if (done) begin
      done_rc = int'(result_col);
      done_rv = int'(result_valid);
    end
    @(posedge clk);
    m_rv = 0;
    if (r) begin
      phase = 0; words = 0; beats = 0; m_rc = 0;
    end else begin
      case (phase)
        0: if (s) phase = 1;
        1: if (dv) begin
             words++;
             if (words == 64) begin phase = 2; words = 0; end
           end
        2: if (wv) begin
             // Results lag the chain by 15 beats: beat k carries column k-15.
             if (beats >= 15) begin m_rv = 1; m_rc = beats - 15; end
             beats++;
             if (beats == 640) begin phase = 3; beats = 0; end
           end
        default: phase = 0;
      endcase
    end
    #1;
  endtask

  task automatic clear_tallies();
    cnt_ldn = 0; cnt_lw = 0; cnt_rv = 0;
    last_row = 0; last_grp = 0; last_rc = 0; done_rc = -1; done_rv = -1;
  endtask

  initial begin
    int guard;
    rst = 1'b1; start = 1'b0; desc_valid = 1'b0; win_valid = 1'b0;
    @(posedge clk); #1;

    // Reset held with random inputs.
    for (int i = 0; i < 2; i++)
      step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));

    // Full descriptor load, back to back.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    clear_tallies();
    for (int w = 0; w < 64; w++) begin
      step(1'b0, 1'b0, 1'b1, 1'($urandom));
      if (w == 0) begin chk("word0_row", 32'(last_row), 32'h0001); chk("word0_grp", 32'(last_grp), 32'h1); end
      if (w == 5) begin chk("word5_row", 32'(last_row), 32'h0002); chk("word5_grp", 32'(last_grp), 32'h2); end
    end
    chk("word63_row", 32'(last_row), 32'h8000);
    chk("word63_grp", 32'(last_grp), 32'h8);
    chk("load_pulses", 32'(cnt_ldn), 32'd64);

    // Continuous scan, start pulsed at beat 100 must be ignored.
    clear_tallies();
    for (int b = 0; b < 640; b++) begin
      step(1'b0, b == 100, 1'($urandom), 1'b1);
      if (b == 15) chk("first_result_none_yet", 32'(cnt_rv), 32'd0);
      if (b == 16) begin chk("first_result_count", 32'(cnt_rv), 32'd1); chk("first_result_col", 32'(last_rc), 32'd0); end
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);   // done cycle
    chk("scan_results", 32'(cnt_rv), 32'd625);
    chk("last_result_col", 32'(last_rc), 32'd624);
    chk("done_col", 32'(done_rc), 32'd624);
    chk("done_with_valid", 32'(done_rv), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);   // back in idle, busy low
    chk("idle_after_done", 32'(busy), 32'd0);

    // Bubbles on both handshakes, then random valid patterns.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    clear_tallies();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("bubble_load_pulses", 32'(cnt_ldn), 32'd2);
    chk("bubble_word1_row", 32'(last_row), 32'h0001);
    chk("bubble_word1_grp", 32'(last_grp), 32'h2);
    guard = 0;
    while (phase == 1 && guard < 2000) begin
      step(1'b0, 1'($urandom), 1'($urandom_range(0, 1)), 1'($urandom));
      guard++;
    end
    chk("bubble_load_bound", 32'(guard < 2000), 32'd1);
    clear_tallies();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("bubble_win_pulses", 32'(cnt_lw), 32'd2);
    guard = 0;
    while (phase == 2 && guard < 5000) begin
      step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));
      guard++;
    end
    chk("bubble_scan_bound", 32'(guard < 5000), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);   // done cycle
    chk("bubble_results", 32'(cnt_rv), 32'd625);
    chk("bubble_done_col", 32'(done_rc), 32'd624);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a scan, then a fresh match.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int w = 0; w < 64; w++) step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int b = 0; b < 300; b++) step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
    step(1'b0, 1'b0, 1'b1, 1'b1);   // idle: every output must be 0
    chk("post_reset_busy", 32'(busy), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    clear_tallies();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("restart_row", 32'(last_row), 32'h0001);
    chk("restart_grp", 32'(last_grp), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
